// File: rtl/digit_scan_pkg.sv
// digit_scan_pkg: shared helpers for the digit scan counter and its prescaler
package digit_scan_pkg;

    function automatic int clog2_min1(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic SEL_OFF(input logic act_low);
        return act_low;
    endfunction

    function automatic logic sel_level(input logic [7:0] count, input int digit, input logic act_low);
        return (int'(count) == digit) ? ~SEL_OFF(act_low) : SEL_OFF(act_low);
    endfunction

endpackage

// File: rtl/digit_scan_cnt_tick_div.sv
// tick_div: counts enabled cycles and flags every DIV-th one as a tick
module tick_div
    import digit_scan_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int PW = clog2_min1(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] p;

    assign tick = (p == LAST);

    // prescale count: cleared by load, frozen while en is low, wraps on the tick cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) p <= '0;
        else if (clr) p <= '0;
        else if (en) p <= tick ? '0 : p + 1'b1;
    end

endmodule

// File: rtl/digit_scan_cnt.sv
// digit_scan_cnt: modulo up/down digit scan counter with load, tc pulse and one-hot select
// Optional prescaler compiled in with `define DIGIT_SCAN_CNT_PRESCALE_EN
module digit_scan_cnt
    import digit_scan_pkg::*;
#(
    parameter int WIDTH       = 3,
    parameter int MODULUS     = 8,
    parameter int DIV         = 4,
    parameter bit SEL_ACT_LOW = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               up,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    output logic [WIDTH-1:0]   q,
    output logic               tc,
    output logic [MODULUS-1:0] sel
);
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD = (WIDTH + 1)'(MODULUS);
    localparam logic             OFF = SEL_OFF(SEL_ACT_LOW);

    logic               adv;
    logic [WIDTH-1:0]   q_nx;
    logic               tc_nx;
    logic [MODULUS-1:0] sel_nx;

`ifdef DIGIT_SCAN_CNT_PRESCALE_EN
    logic tick;

    tick_div #(.DIV(DIV)) u_div (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (load),
        .tick(tick)
    );

    assign adv = en && tick;
`else
    assign adv = en;
`endif

    // next count and wrap pulse; wraps compare against the modulus explicitly
    always_comb begin
        q_nx  = load ? (({1'b0, load_val} < MOD) ? load_val : '0)
              : !adv ? q
              : up ? ((q == TOP) ? '0 : q + 1'b1)
              : ((q == '0) ? TOP : q - 1'b1);
        tc_nx = !load && adv && (up ? (q == TOP) : (q == '0));
    end

    for (genvar g = 0; g < MODULUS; g++) begin : g_sel
        assign sel_nx[g] = sel_level(8'(q_nx), g, SEL_ACT_LOW);
    end

    // output registers; select is decoded from the next count so it lines up with q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= '0;
            tc  <= 1'b0;
            sel <= {{(MODULUS - 1){OFF}}, ~OFF};
        end else begin
            q   <= q_nx;
            tc  <= tc_nx;
            sel <= sel_nx;
        end
    end

endmodule
